// File: rtl/led_status_ctrl.sv
// Status-LED driver: per-channel OFF/ON/BLINK/STRETCH with a shared free-running prescaler.
// Optional per-channel PWM dimming when LED_STATUS_PWM_EN is defined.
module led_status_ctrl #(
   parameter int NumLeds     = 8,
   parameter int CntW        = 32,
   parameter int BaseShift   = 20,
   parameter int HeartbeatCh = 0,
   parameter int ActiveLow   = 0
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       cfg_we_i,
   input  logic [$clog2(NumLeds):0]   cfg_addr_i,
   input  logic [15:0]                cfg_wdata_i,
   input  logic [NumLeds-1:0]         event_i,
   output logic [NumLeds-1:0]         led_o
);

   localparam int AW   = $clog2(NumLeds) + 1;
   localparam int KW   = (CntW > 1) ? $clog2(CntW) : 1;
   localparam int KMax = CntW - 1;
   localparam logic [AW-1:0] LastAddr = AW'(NumLeds - 1);
   localparam logic InvBit = (ActiveLow != 0);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_ON      = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_STRETCH = 2'd3
   } mode_t;

   logic [CntW-1:0]    r_presc;
   logic               w_addr_ok;
   logic [NumLeds-1:0] w_led_nxt;

   assign w_addr_ok = cfg_we_i && (cfg_addr_i <= LastAddr);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_presc <= '0;
      else         r_presc <= r_presc + 1'b1;
   end

`ifdef LED_STATUS_PWM_EN
   logic [7:0] r_pwm;
   logic [1:0] w_unused_wdata;
   assign w_unused_wdata = cfg_wdata_i[7:6];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_pwm <= '0;
      else         r_pwm <= r_pwm + 8'd1;
   end
`else
   logic [9:0] w_unused_wdata;
   assign w_unused_wdata = cfg_wdata_i[15:6];
`endif

   generate
      for (genvar gi = 0; gi < NumLeds; gi++) begin : g_ch
         mode_t           r_mode;
         logic [3:0]      r_div;
         logic [CntW-1:0] r_cnt;
         logic [CntW-1:0] w_cnt_next;
         logic [CntW-1:0] w_load;
         logic [KW-1:0]   w_k;
         logic            w_wr;
         logic            w_evt;
         logic            w_nxt;
         logic            w_gate;
         int              w_k_raw;

         assign w_wr  = w_addr_ok && (cfg_addr_i == AW'(gi));
         // A write on the same cycle as an event wins: the event is dropped.
         assign w_evt = event_i[gi] & ~w_wr;

         always_comb begin
            w_k_raw = BaseShift + int'(r_div);
            w_k     = (w_k_raw > KMax) ? KW'(KMax) : KW'(w_k_raw);
            w_load  = {CntW{1'b1}} >> (CntW - int'(w_k));
         end

         always_comb begin
            w_nxt      = 1'b0;
            w_cnt_next = r_cnt;
            case (r_mode)
               MODE_OFF:   w_nxt = 1'b0;
               MODE_ON:    w_nxt = 1'b1;
               MODE_BLINK: w_nxt = r_presc[w_k];
               MODE_STRETCH: begin
                  if (w_evt) begin
                     w_cnt_next = w_load;
                     w_nxt      = 1'b1;
                  end else if (r_cnt != '0) begin
                     w_cnt_next = r_cnt - 1'b1;
                     w_nxt      = 1'b1;
                  end
               end
               default: w_nxt = 1'b0;
            endcase
            if (w_wr) w_cnt_next = '0;
         end

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               r_mode <= (gi == HeartbeatCh) ? MODE_BLINK : MODE_OFF;
               r_div  <= (gi == HeartbeatCh) ? 4'd5 : 4'd0;
               r_cnt  <= '0;
            end else begin
               if (w_wr) begin
                  r_mode <= mode_t'(cfg_wdata_i[1:0]);
                  r_div  <= cfg_wdata_i[5:2];
               end
               r_cnt <= w_cnt_next;
            end
         end

`ifdef LED_STATUS_PWM_EN
         logic [7:0] r_duty;

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)   r_duty <= 8'hFF;
            else if (w_wr) r_duty <= cfg_wdata_i[15:8];
         end

         assign w_gate = (r_duty == 8'hFF) | (r_pwm < r_duty);
`else
         assign w_gate = 1'b1;
`endif

         assign w_led_nxt[gi] = w_nxt & w_gate;
      end
   endgenerate

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) led_o <= {NumLeds{InvBit}};
      else         led_o <= w_led_nxt ^ {NumLeds{InvBit}};
   end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl (NumLeds=4, CntW=8, BaseShift=2, HeartbeatCh=0).
// Step n = n-th rising edge after reset release; outputs sampled 1 time unit after each edge.
module tb_led_status_ctrl;

   logic        clk_i;
   logic        rst_ni;
   logic        cfg_we_i;
   logic [2:0]  cfg_addr_i;
   logic [15:0] cfg_wdata_i;
   logic [3:0]  event_i;
   logic [3:0]  led_o;

   int n_checks;
   int n_errors;
   int cyc;

   led_status_ctrl #(
      .NumLeds(4), .CntW(8), .BaseShift(2), .HeartbeatCh(0), .ActiveLow(0)
   ) dut (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .cfg_we_i   (cfg_we_i),
      .cfg_addr_i (cfg_addr_i),
      .cfg_wdata_i(cfg_wdata_i),
      .event_i    (event_i),
      .led_o      (led_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (step %0d)", tag, obs, exp, cyc);
      end else begin
         $display("check %s: %0h ok (step %0d)", tag, obs, cyc);
      end
   endtask

   task automatic run_to(input int target);
      while (cyc < target) begin
         @(posedge clk_i);
         #1;
         cyc++;
      end
   endtask

   // Single-cycle config write; registers load at the next edge.
   task automatic wr(input logic [2:0] addr, input logic [15:0] data);
      cfg_we_i    = 1'b1;
      cfg_addr_i  = addr;
      cfg_wdata_i = data;
      run_to(cyc + 1);
      cfg_we_i    = 1'b0;
   endtask

   task automatic pulse(input logic [3:0] ev);
      event_i = ev;
      run_to(cyc + 1);
      event_i = 4'b0000;
   endtask

   task automatic release_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      cyc    = 0;
   endtask

`ifdef LED_STATUS_PWM_EN
   task automatic pwm_count(input string tag, input logic [15:0] data, input int exp);
      int hi;
      hi = 0;
      wr(3'd3, data);
      for (int i = 0; i < 256; i++) begin
         run_to(cyc + 1);
         if (led_o[3]) hi++;
      end
      check(tag, hi, exp);
   endtask
`endif

   initial begin
      n_checks    = 0;
      n_errors    = 0;
      cyc         = 0;
      rst_ni      = 1'b0;
      cfg_we_i    = 1'b0;
      cfg_addr_i  = 3'd0;
      cfg_wdata_i = 16'h0000;
      event_i     = 4'b0000;

      #12;
      check("reset_led", led_o, 4'b0000);
      repeat (2) @(posedge clk_i);
      release_reset();

      // Heartbeat: k=7, led_o[0] after step n is bit 7 of (n-1).
      run_to(1);   check("hb_s1",   led_o, 4'b0000);
      run_to(128); check("hb_s128", led_o, 4'b0000);
      run_to(129); check("hb_s129", led_o, 4'b0001);
      run_to(256); check("hb_s256", led_o, 4'b0001);
      run_to(257); check("hb_s257", led_o, 4'b0000);

      // ch1 BLINK div 0 (k=2): loads at step 258, visible from 259.
      wr(3'd1, 16'h0002);
      check("bl_s258", led_o, 4'b0000);
      run_to(260); check("bl_s260", led_o, 4'b0000);
      run_to(261); check("bl_s261", led_o, 4'b0010);
      run_to(264); check("bl_s264", led_o, 4'b0010);
      run_to(265); check("bl_s265", led_o, 4'b0000);
      run_to(269); check("bl_s269", led_o, 4'b0010);

      // ch2 STRETCH div 1 (k=3): 8-cycle pulse.
      wr(3'd2, 16'h0007);
      check("st_s270", led_o[2], 1'b0);
      pulse(4'b0100);
      check("st_s271", led_o[2], 1'b1);
      run_to(278); check("st_s278", led_o[2], 1'b1);
      run_to(279); check("st_s279", led_o[2], 1'b0);
      run_to(280); check("st_s280", led_o[2], 1'b0);

      // Retrigger 5 cycles later extends to 8 cycles from the second event.
      pulse(4'b0100);
      check("rt_s281", led_o[2], 1'b1);
      run_to(285);
      pulse(4'b0100);
      check("rt_s286", led_o[2], 1'b1);
      run_to(293); check("rt_s293", led_o[2], 1'b1);
      run_to(294); check("rt_s294", led_o[2], 1'b0);

      // Event exactly in the expiry cycle: no low gap.
      run_to(300);
      pulse(4'b0100);
      run_to(308);
      pulse(4'b0100);
      check("ex_s309", led_o[2], 1'b1);
      run_to(316); check("ex_s316", led_o[2], 1'b1);
      run_to(317); check("ex_s317", led_o[2], 1'b0);

      // Out-of-range address must not alias onto ch0.
      wr(3'd4, 16'h0001);
      run_to(320);
      check("oor_ch3", led_o[3], 1'b0);
      check("oor_ch0", led_o[0], 1'b0);

      // Write and event on ch3 in the same cycle: event dropped.
      cfg_we_i    = 1'b1;
      cfg_addr_i  = 3'd3;
      cfg_wdata_i = 16'h0003;
      event_i     = 4'b1000;
      run_to(321);
      cfg_we_i    = 1'b0;
      event_i     = 4'b0000;
      check("col_s321", led_o[3], 1'b0);
      run_to(322); check("col_s322", led_o[3], 1'b0);
      run_to(324); check("col_s324", led_o[3], 1'b0);
      pulse(4'b1000);
      check("col_s325", led_o[3], 1'b1);

      // Event ignored in non-STRETCH mode (ch1 BLINK, step 327 sees prescaler 70 -> bit2=1).
      run_to(328);
      pulse(4'b0010);
      check("nst_s329", led_o[1], 1'b0);

      // Async reset in the middle of a stretch pulse.
      pulse(4'b0100);
      check("mr_s330", led_o[2], 1'b1);
      run_to(331);
      #2;
      rst_ni = 1'b0;
      #1;
      check("mr_async", led_o, 4'b0000);
      repeat (2) @(posedge clk_i);
      #1;
      check("mr_hold", led_o, 4'b0000);
      release_reset();
      run_to(1);   check("mr_s1",   led_o, 4'b0000);
      run_to(128); check("mr_s128", led_o, 4'b0000);
      run_to(129); check("mr_s129", led_o, 4'b0001);

`ifdef LED_STATUS_PWM_EN
      pwm_count("pwm_duty40", 16'h4001, 64);
      pwm_count("pwm_duty00", 16'h0001, 0);
      pwm_count("pwm_dutyff", 16'hFF01, 256);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
